// File: rtl/sincos_arb.sv
`default_nettype none
// ============================================================================
// Module   : sincos_arb
// Purpose  : Round-robin arbiter sharing one fixed-latency sincos pipeline
//            among NREQ requesters. Each requester has at most one operation
//            in flight or unread. Results are returned in per-requester
//            holding registers until acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module sincos_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 48,
  parameter int LAT   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_angle,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*WIDTH-1:0] rsp_sin,
  output logic [NREQ*WIDTH-1:0] rsp_cos,
  input  logic [NREQ-1:0]       rsp_ack,
  output logic [WIDTH-1:0]      sc_angle,
  output logic                  sc_issue,
  input  logic [WIDTH-1:0]      sc_sin,
  input  logic [WIDTH-1:0]      sc_cos,
  output logic                  idle
);

  localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Arbitration state
  logic [NREQ-1:0]  r_pend;
  logic [c_IW-1:0]  r_ptr;
  logic [NREQ-1:0]  w_elig;
  logic             w_gnt_any;
  logic [c_IW-1:0]  w_gnt_idx;
  logic [c_IW-1:0]  w_ptr_nxt;
  logic [NREQ-1:0]  w_ready;
  logic [WIDTH-1:0] w_gnt_angle;
  int               w_j;

  // Issue stage towards the sincos unit
  logic             r_sc_issue;
  logic [c_IW-1:0]  r_sc_idx;
  logic [WIDTH-1:0] r_sc_angle;

  // Tag pipeline tracking which requester owns each sincos stage
  logic [LAT-1:0]   r_tag_v;
  logic [c_IW-1:0]  r_tag_idx [LAT];

  // Response holding registers
  logic [NREQ-1:0]       r_rsp_valid;
  logic [NREQ*WIDTH-1:0] r_rsp_sin;
  logic [NREQ*WIDTH-1:0] r_rsp_cos;
  logic [NREQ-1:0]       w_wr;
  logic [NREQ-1:0]       w_ack;

  assign w_elig = req_valid & ~r_pend;

  // Round-robin search: first eligible requester starting at r_ptr
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_gnt_any && w_elig[w_j[c_IW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_j[c_IW-1:0];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == c_IW'(NREQ - 1)) ? '0 : w_gnt_idx + c_IW'(1);

  // One-hot ready for the winner and mux of its angle; ready masked in reset
  always_comb begin
    w_ready     = '0;
    w_gnt_angle = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_any && (w_gnt_idx == c_IW'(i))) begin
        w_ready[i]  = reset_n;
        w_gnt_angle = req_angle[i*WIDTH +: WIDTH];
      end
    end
  end

  // Decode of the tag leaving the pipeline and of qualified acknowledges
  always_comb begin
    w_wr  = '0;
    w_ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_wr[i]  = r_tag_v[LAT-1] && (r_tag_idx[LAT-1] == c_IW'(i));
      w_ack[i] = rsp_ack[i] & r_rsp_valid[i];
    end
  end

  // Pending flags and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_ptr  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_ack) | w_ready;
      if (w_gnt_any) r_ptr <= w_ptr_nxt;
    end
  end

  // Register the granted angle and its owner into the issue stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sc_issue <= 1'b0;
      r_sc_idx   <= '0;
      r_sc_angle <= '0;
    end else begin
      r_sc_issue <= w_gnt_any;
      if (w_gnt_any) begin
        r_sc_idx   <= w_gnt_idx;
        r_sc_angle <= w_gnt_angle;
      end
    end
  end

  // Shift tags alongside the sincos pipeline; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tag_v <= '0;
      for (int k = 0; k < LAT; k++) r_tag_idx[k] <= '0;
    end else begin
      r_tag_v[0]   <= r_sc_issue;
      r_tag_idx[0] <= r_sc_idx;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  // Capture results into the owner's slice and hold them until acknowledged
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_valid <= '0;
      r_rsp_sin   <= '0;
      r_rsp_cos   <= '0;
    end else begin
      r_rsp_valid <= (r_rsp_valid & ~w_ack) | w_wr;
      for (int i = 0; i < NREQ; i++) begin
        if (w_wr[i]) begin
          r_rsp_sin[i*WIDTH +: WIDTH] <= sc_sin;
          r_rsp_cos[i*WIDTH +: WIDTH] <= sc_cos;
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sin   = r_rsp_sin;
  assign rsp_cos   = r_rsp_cos;
  assign sc_angle  = r_sc_angle;
  assign sc_issue  = r_sc_issue;
  assign idle      = ~|r_pend;

endmodule
`default_nettype wire

// File: tb/tb_sincos_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sincos_arb
// Purpose  : Directed scoreboard bench for sincos_arb with a stub sincos unit
//            (sin = angle+1, cos = angle+2, LAT cycles later).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sincos_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 48;
  localparam int LAT   = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_angle;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*WIDTH-1:0] rsp_sin;
  logic [NREQ*WIDTH-1:0] rsp_cos;
  logic [NREQ-1:0]       rsp_ack;
  logic [WIDTH-1:0]      sc_angle;
  logic                  sc_issue;
  logic [WIDTH-1:0]      sc_sin;
  logic [WIDTH-1:0]      sc_cos;
  logic                  idle;

  always #5 clk = ~clk;

  sincos_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sin   (rsp_sin),
    .rsp_cos   (rsp_cos),
    .rsp_ack   (rsp_ack),
    .sc_angle  (sc_angle),
    .sc_issue  (sc_issue),
    .sc_sin    (sc_sin),
    .sc_cos    (sc_cos),
    .idle      (idle)
  );

  // Stub sincos unit: fixed LAT-cycle delay line
  logic [WIDTH-1:0] sc_pipe [LAT];
  always @(posedge clk) begin
    sc_pipe[0] <= sc_angle;
    for (int k = 1; k < LAT; k++) sc_pipe[k] <= sc_pipe[k-1];
  end
  assign sc_sin = sc_pipe[LAT-1] + 48'd1;
  assign sc_cos = sc_pipe[LAT-1] + 48'd2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    int               at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop on each rising rsp_valid, check data/latency, then check hold
  logic [NREQ-1:0]  prev_v = '0;
  logic [WIDTH-1:0] held_s [NREQ];
  logic [WIDTH-1:0] held_c [NREQ];
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i] && !prev_v[i]) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: actual=response on requester %0d required=none (cycle %0d)", i, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_idx", 64'(i), 64'(e.idx));
          chk("rsp_sin", 64'(rsp_sin[i*WIDTH +: WIDTH]), 64'(e.s));
          chk("rsp_cos", 64'(rsp_cos[i*WIDTH +: WIDTH]), 64'(e.c));
          chk("rsp_cycle", 64'(cyc), 64'(e.at));
        end
        held_s[i] = rsp_sin[i*WIDTH +: WIDTH];
        held_c[i] = rsp_cos[i*WIDTH +: WIDTH];
      end else if (rsp_valid[i] && prev_v[i]) begin
        chk("rsp_hold_sin", 64'(rsp_sin[i*WIDTH +: WIDTH]), 64'(held_s[i]));
        chk("rsp_hold_cos", 64'(rsp_cos[i*WIDTH +: WIDTH]), 64'(held_c[i]));
      end
    end
    prev_v = rsp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_angle(input int i, input logic [WIDTH-1:0] a);
    req_angle[i*WIDTH +: WIDTH] = a;
  endtask

  task automatic push(input int i, input logic [WIDTH-1:0] a);
    sb.push_back('{i, a + 48'd1, a + 48'd2, cyc + LAT + 2});
  endtask

  task automatic wait_valid(input int i, input int maxc);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < maxc) begin
      tick();
      n++;
    end
    chk("wait_rsp_valid", 64'(rsp_valid[i]), 64'(1));
  endtask

  task automatic ack_once(input logic [NREQ-1:0] m);
    rsp_ack = m;
    tick();
    rsp_ack = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] exp_r;
    reset_n   = 1'b0;
    req_valid = '0;
    req_angle = '0;
    rsp_ack   = '0;
    tick();

    // Reset: ready masked even with requests present, clean state afterwards
    req_valid = '1;
    settle();
    chk("ready_in_reset", 64'(req_ready), 64'(0));
    tick();
    req_valid = '0;
    reset_n   = 1'b1;
    settle();
    chk("reset_idle", 64'(idle), 64'(1));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_sc_issue", 64'(sc_issue), 64'(0));
    chk("reset_sc_angle", 64'(sc_angle), 64'(0));
    repeat (3) tick();

    // Single request on requester 2
    set_angle(2, 48'h10);
    req_valid = 4'b0100;
    settle();
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    push(2, 48'h10);
    tick();
    req_valid = '0;
    settle();
    chk("single_issue", 64'(sc_issue), 64'(1));
    chk("single_angle", 64'(sc_angle), 64'(48'h10));
    chk("single_idle_busy", 64'(idle), 64'(0));
    tick();
    settle();
    chk("single_issue_drop", 64'(sc_issue), 64'(0));
    chk("single_angle_hold", 64'(sc_angle), 64'(48'h10));
    wait_valid(2, 30);
    chk("single_others", 64'(rsp_valid), 64'(4'b0100));
    ack_once(4'b0100);
    settle();
    chk("single_ack_clear", 64'(rsp_valid), 64'(0));
    chk("single_idle", 64'(idle), 64'(1));

    // All four at once from a freshly reset pointer
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int g = 0; g < NREQ; g++) set_angle(g, 48'(32'h100 * (g + 1)));
    req_valid = 4'hF;
    for (int g = 0; g < NREQ; g++) begin
      settle();
      exp_r = '0;
      exp_r[g] = 1'b1;
      chk("all4_ready", 64'(req_ready), 64'(exp_r));
      push(g, 48'(32'h100 * (g + 1)));
      tick();
      req_valid[g] = 1'b0;
    end
    wait_valid(3, 40);
    chk("all4_valid", 64'(rsp_valid), 64'(4'hF));
    ack_once(4'hF);
    settle();
    chk("all4_ack_clear", 64'(rsp_valid), 64'(0));
    chk("all4_idle", 64'(idle), 64'(1));

    // Fairness: requesters 0 and 3 held valid with immediate acks
    set_angle(0, 48'hA0);
    set_angle(3, 48'hD0);
    for (int k = 0; k < 60; k++) begin
      req_valid = (k <= 39) ? 4'b1001 : 4'b0000;
      rsp_ack   = rsp_valid;
      settle();
      if (k == 0 || k == 19 || k == 38)      exp_r = 4'b0001;
      else if (k == 1 || k == 20 || k == 39) exp_r = 4'b1000;
      else                                    exp_r = 4'b0000;
      chk("fair_ready", 64'(req_ready), 64'(exp_r));
      if (exp_r == 4'b0001) push(0, 48'hA0);
      if (exp_r == 4'b1000) push(3, 48'hD0);
      tick();
    end
    rsp_ack = '0;
    settle();
    chk("fair_idle", 64'(idle), 64'(1));

    // Backpressure: requester 1 never acked for a long window
    set_angle(1, 48'h55);
    set_angle(2, 48'h77);
    for (int k = 0; k < 120; k++) begin
      req_valid = (k == 30) ? 4'b0110 : 4'b0010;
      if (k == 1) set_angle(1, 48'h66);
      rsp_ack = rsp_valid & 4'b0100;
      settle();
      if (k == 0)       exp_r = 4'b0010;
      else if (k == 30) exp_r = 4'b0100;
      else              exp_r = 4'b0000;
      chk("bp_ready", 64'(req_ready), 64'(exp_r));
      if (k == 0)  push(1, 48'h55);
      if (k == 30) push(2, 48'h77);
      tick();
    end
    chk("bp_held_sin", 64'(rsp_sin[1*WIDTH +: WIDTH]), 64'(48'h56));
    chk("bp_held_valid", 64'(rsp_valid), 64'(4'b0010));
    // Ack together with a waiting request: accept only on the next cycle
    rsp_ack = 4'b0010;
    settle();
    chk("ack_cycle_ready", 64'(req_ready), 64'(0));
    tick();
    rsp_ack = '0;
    settle();
    chk("after_ack_ready", 64'(req_ready), 64'(4'b0010));
    push(1, 48'h66);
    tick();
    req_valid = '0;
    wait_valid(1, 30);
    ack_once(4'b0010);
    settle();
    chk("bp_idle", 64'(idle), 64'(1));

    // Stray ack with nothing held
    ack_once(4'b0001);
    settle();
    chk("stray_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("stray_idle", 64'(idle), 64'(1));
    set_angle(0, 48'h20);
    req_valid = 4'b0001;
    settle();
    chk("stray_next_ready", 64'(req_ready), 64'(4'b0001));
    push(0, 48'h20);
    tick();
    req_valid = '0;
    wait_valid(0, 30);
    ack_once(4'b0001);

    // Reset eight cycles after an issue discards the in-flight operation
    set_angle(0, 48'h30);
    req_valid = 4'b0001;
    settle();
    chk("mid_reset_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    settle();
    chk("mid_reset_issue", 64'(sc_issue), 64'(1));
    repeat (8) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    settle();
    chk("mid_reset_idle", 64'(idle), 64'(1));
    chk("mid_reset_sc_issue", 64'(sc_issue), 64'(0));
    for (int k = 0; k < 30; k++) begin
      tick();
      settle();
      chk("post_reset_quiet", 64'(rsp_valid), 64'(0));
      chk("post_reset_idle", 64'(idle), 64'(1));
    end
    set_angle(3, 48'h40);
    req_valid = 4'b1000;
    settle();
    chk("fresh_ready", 64'(req_ready), 64'(4'b1000));
    push(3, 48'h40);
    tick();
    req_valid = '0;
    wait_valid(3, 30);
    ack_once(4'b1000);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sincos_arb.md
SINCOS_ARB -- requirements
Module: sincos_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one sincos unit.
REQ-002 Parameter WIDTH, default 48, fixed-point angle/result width.
REQ-003 Parameter LAT, default 16, fixed pipeline latency of the shared sincos unit, angle-in to sin/cos-out, in cycles.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  NREQ  requester i has an angle to convert.
REQ-007 req_angle  in  NREQ*WIDTH  angle of requester i in bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  out  NREQ  requester i accepted this cycle when req_valid[i] is also high.
REQ-009 rsp_valid  out  NREQ  result for requester i is held.
REQ-010 rsp_sin  out  NREQ*WIDTH  sin result of requester i, slice as REQ-007.
REQ-011 rsp_cos  out  NREQ*WIDTH  cos result of requester i, slice as REQ-007.
REQ-012 rsp_ack  in  NREQ  requester i consumes its result.
REQ-013 sc_angle  out  WIDTH  angle driven to sincos unit.
REQ-014 sc_issue  out  1  sc_angle carries a live operand this cycle.
REQ-015 sc_sin, sc_cos  in  WIDTH each  sincos unit outputs.
REQ-016 idle  out  1  high when nothing is in flight and no rsp_valid is set.

Function
REQ-017 Per requester, pend[i] SHALL be set on accept and cleared only on rsp_ack[i] while rsp_valid[i]; at most one operation per requester in flight or unread.
REQ-018 Eligible[i] = req_valid[i] & ~pend[i]; at most one eligible requester is granted per cycle.
REQ-019 Grant SHALL be round-robin: search starts at pointer ptr, ptr becomes (granted index + 1) mod NREQ after each grant, unchanged when no grant.
REQ-020 req_ready[i] SHALL be combinational: high only for the granted index; req_ready SHALL never depend on req_angle.
REQ-021 Accept at cycle t SHALL register the angle: sc_angle = angle and sc_issue = 1 at cycle t+1; with no accept at t, sc_issue = 0 at t+1 and sc_angle holds.
REQ-022 A tag pipeline (valid bit + index, LAT stages) SHALL shift every cycle from sc_issue; the sc_sin/sc_cos sampled at cycle t+1+LAT belong to the tag leaving the pipeline.
REQ-023 Matching sc_sin/sc_cos SHALL be registered into slice i, with rsp_valid[i] high at cycle t+2+LAT (total latency LAT+2 from accept).
REQ-024 rsp_sin/rsp_cos/rsp_valid of slice i SHALL hold stable until rsp_ack[i]; rsp_valid[i] falls the cycle after ack.
REQ-025 rsp_ack[i] with rsp_valid[i] low SHALL be ignored.
REQ-026 pend is registered, so ack at cycle a permits a new accept for that requester at a+1 at earliest.
REQ-027 Back-to-back accepts (one per cycle, different requesters) SHALL be sustained; the sincos unit is never stalled.
REQ-028 idle = ~|pend.

Reset
REQ-029 While reset_n is low at a clock edge: pend, rsp_valid, rsp_sin, rsp_cos, sc_angle, sc_issue, tag valids, ptr SHALL clear to 0; req_ready = 0; idle = 1 the cycle after.
REQ-030 Reset mid-operation SHALL discard all in-flight tags; late sincos outputs SHALL never set rsp_valid.

Verification (LAT=16; stub sincos returns sin = angle+1, cos = angle+2 after 16 cycles)
REQ-031 Single: req_valid[2], angle 0x10 accepted at cycle 5 -> sc_issue at 6, rsp_valid[2] at 23, rsp_sin 0x11, rsp_cos 0x12, others untouched.
REQ-032 All four valid at cycle 5, ptr 0 -> grants 0,1,2,3 at cycles 5-8; rsp_valid rises at 23,24,25,26.
REQ-033 Fairness: req 0 and 3 held valid, immediate acks -> grants alternate 0,3,0,3; neither starves.
REQ-034 Backpressure: no ack on requester 1 for 100 cycles -> req_ready[1] stays 0, rsp_sin/cos[1] stable, other requesters proceed.
REQ-035 Reset 8 cycles after an issue, held 1 cycle -> rsp_valid stays 0 indefinitely, idle = 1; fresh request afterwards completes in 18 cycles.
REQ-036 Stray rsp_ack[0] with rsp_valid[0] = 0 -> no state change; ack concurrent with new req_valid on same requester -> accept occurs one cycle later.
